// File: rtl/mesh_term_src.sv
// Source queue for one mesh terminal: buffers agent packets in a first-word-fall-through FIFO.
// Optional destination filtering is enabled with `define MESH_TERM_SRC_DEST_CHECK_EN.
module mesh_term_src #(
  parameter int ROWS       = 4,
  parameter int COLUMS     = 4,
  parameter int pckg_sz    = 40,
  parameter int fifo_depth = 4,
  parameter int ID_ROW     = 0,
  parameter int ID_COL     = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              push,
  input  logic [pckg_sz-1:0]                data_in,
  output logic                              full,
  output logic                              overflow,
  output logic [$clog2(fifo_depth+1)-1:0]   count,
  output logic                              pndng_i_in,
  output logic [pckg_sz-1:0]                data_out_i_in,
  input  logic                              popin,
  output logic [15:0]                       drop_cnt
);

  localparam int CNT_W = $clog2(fifo_depth + 1);
  localparam int PTR_W = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(fifo_depth - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(fifo_depth);

  logic [pckg_sz-1:0] mem_q [fifo_depth];
  logic [pckg_sz-1:0] mem_d [fifo_depth];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               dest_ok, push_ok, pop_ok, is_full, is_empty;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == FULL_CNT);

`ifdef MESH_TERM_SRC_DEST_CHECK_EN
  logic [3:0]  dst_row, dst_col;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  assign dst_row = data_in[pckg_sz-9 -: 4];
  assign dst_col = data_in[pckg_sz-13 -: 4];
  assign dest_ok = !((int'(dst_row) > ROWS + 1) ||
                     (int'(dst_col) > COLUMS + 1) ||
                     ((dst_row == 4'(ID_ROW)) && (dst_col == 4'(ID_COL))));

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (push && !dest_ok && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign dest_ok  = 1'b1;
  assign drop_cnt = '0;
`endif

  // A pop on the same edge frees the slot, so a full FIFO still accepts a push with popin.
  assign push_ok = push && dest_ok && (!is_full || popin);
  assign pop_ok  = popin && !is_empty;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (push && dest_ok && is_full && !popin);
    if (push_ok) begin
      mem_d[wr_ptr_q] = data_in;
      wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < fifo_depth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign count         = count_q;
  assign full          = is_full;
  assign pndng_i_in    = !is_empty;
  assign data_out_i_in = mem_q[rd_ptr_q];
  assign overflow      = overflow_q;

endmodule
